// File: rtl/mdu_iterative_pkg.sv
// rtl/mdu_iterative_pkg.sv - MDU op codes, FSM state encoding and op classification helpers
package mdu_iterative_pkg;

  localparam logic [2:0] MDU_MULT  = 3'd0;
  localparam logic [2:0] MDU_MULTU = 3'd1;
  localparam logic [2:0] MDU_DIV   = 3'd2;
  localparam logic [2:0] MDU_DIVU  = 3'd3;
  localparam logic [2:0] MDU_MTHI  = 3'd4;
  localparam logic [2:0] MDU_MTLO  = 3'd5;
  localparam logic [2:0] MDU_NOP   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_FIXUP = 2'd2
  } mdu_state_e;

  function automatic logic op_is_arith(input logic [2:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic logic op_is_signed(input logic [2:0] op);
    return (op == MDU_MULT) || (op == MDU_DIV);
  endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// rtl/mdu_sign_fix.sv - conditional two's-complement negate (magnitude / sign restore)
module mdu_sign_fix #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] val_i,
  input  logic         neg_i,
  output logic [W-1:0] res_o
);

  assign res_o = neg_i ? (~val_i + W'(1)) : val_i;

endmodule

// File: rtl/mdu_iterative.sv
// rtl/mdu_iterative.sv - iterative shift-add multiply / restoring divide unit with HI/LO registers
module mdu_iterative
  import mdu_iterative_pkg::*;
#(
  parameter int unsigned       WIDTH   = 32,
  parameter logic [WIDTH-1:0] DIV0_LO = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  mdu_state_e         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   b_mag_q, b_mag_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic               is_div_q, is_div_d;
  logic               neg_lo_q, neg_lo_d;
  logic               neg_rem_q, neg_rem_d;
  logic               div0_q, div0_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic               neg_a, neg_b;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic               div_ok;

  assign neg_a = op_is_signed(op) & a[WIDTH-1];
  assign neg_b = op_is_signed(op) & b[WIDTH-1];

  mdu_sign_fix #(.W(WIDTH))   u_a_mag (.val_i(a),                .neg_i(neg_a),     .res_o(a_mag));
  mdu_sign_fix #(.W(WIDTH))   u_b_mag (.val_i(b),                .neg_i(neg_b),     .res_o(b_mag));
  mdu_sign_fix #(.W(2*WIDTH)) u_prod  (.val_i(acc_q),            .neg_i(neg_lo_q),  .res_o(prod_fix));
  mdu_sign_fix #(.W(WIDTH))   u_quo   (.val_i(acc_q[WIDTH-1:0]), .neg_i(neg_lo_q),  .res_o(quo_fix));
  mdu_sign_fix #(.W(WIDTH))   u_rem   (.val_i(rem_q),            .neg_i(neg_rem_q), .res_o(rem_fix));

  // Multiply: acc holds {partial product, unconsumed multiplier bits}, shifted right each step
  assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_mag_q} : '0);
  // Divide: acc low half shifts the dividend out and the quotient in
  assign div_shift = {rem_q, acc_q[WIDTH-1]};
  assign div_ok    = (div_shift >= {1'b0, b_mag_q});

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    rem_d     = rem_q;
    b_mag_d   = b_mag_q;
    a_d       = a_q;
    is_div_d  = is_div_q;
    neg_lo_d  = neg_lo_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (op_valid) begin
          if (op == MDU_MTHI) begin
            hi_d = a;
          end else if (op == MDU_MTLO) begin
            lo_d = a;
          end else if (op_is_arith(op)) begin
            state_d   = ST_CALC;
            cnt_d     = CW'(WIDTH - 1);
            acc_d     = {{WIDTH{1'b0}}, a_mag};
            rem_d     = '0;
            b_mag_d   = b_mag;
            a_d       = a;
            is_div_d  = (op == MDU_DIV) || (op == MDU_DIVU);
            neg_lo_d  = neg_a ^ neg_b;
            neg_rem_d = neg_a;
            div0_d    = (b == '0);
          end
        end
      end
      ST_CALC: begin
        if (is_div_q) begin
          rem_d = div_ok ? WIDTH'(div_shift - {1'b0, b_mag_q}) : div_shift[WIDTH-1:0];
          acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], div_ok};
        end else begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) state_d = ST_FIXUP;
      end
      ST_FIXUP: begin
        if (!is_div_q) begin
          {hi_d, lo_d} = prod_fix;
        end else if (div0_q) begin
          hi_d = a_q;
          lo_d = DIV0_LO;
        end else begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      rem_q     <= '0;
      b_mag_q   <= '0;
      a_q       <= '0;
      is_div_q  <= 1'b0;
      neg_lo_q  <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      rem_q     <= rem_d;
      b_mag_q   <= b_mag_d;
      a_q       <= a_d;
      is_div_q  <= is_div_d;
      neg_lo_q  <= neg_lo_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign op_ready = (state_q == ST_IDLE);
  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_mdu_iterative.sv
// tb/tb_mdu_iterative.sv - self-checking bench for mdu_iterative against an arithmetic reference model
module tb_mdu_iterative;
  import mdu_iterative_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        op_valid;
  logic        op_ready;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  mdu_iterative #(.WIDTH(32), .DIV0_LO(32'hFFFF_FFFF)) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready), .op(op),
    .a(a), .b(b), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected {hi, lo} straight from the arithmetic definition of each op
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    logic [63:0] res;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    res = '0;
    case (o)
      MDU_MULTU: res = {32'd0, x} * {32'd0, y};
      MDU_MULT:  res = 64'(sx * sy);
      MDU_DIVU:  res = (y == 0) ? {x, 32'hFFFF_FFFF} : {x % y, x / y};
      MDU_DIV: begin
        if (y == 0) res = {x, 32'hFFFF_FFFF};
        else begin
          q = sx / sy;
          r = sx % sy;
          res = {r[31:0], q[31:0]};
        end
      end
      default: res = '0;
    endcase
    return res;
  endfunction

  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input string tag, input bit detail);
    logic [63:0] exp;
    longint      rmag, bmag;
    int          n;
    exp = model(o, x, y);
    op = o; a = x; b = y; op_valid = 1'b1;
    tick();
    op_valid = 1'b0; a = $urandom; b = $urandom;
    n = 1;
    while (done !== 1'b1 && n < 60) begin
      if (detail) begin
        check({tag, " busy"}, 64'(busy), 64'd1);
        check({tag, " ready_low"}, 64'(op_ready), 64'd0);
      end
      tick();
      n++;
    end
    check({tag, " latency"}, 64'(n), 64'd34);
    check({tag, " hilo"}, {hi, lo}, exp);
    if (detail) begin
      check({tag, " busy_done"}, 64'(busy), 64'd0);
      check({tag, " ready_done"}, 64'(op_ready), 64'd1);
    end
    if ((o == MDU_DIV || o == MDU_DIVU) && y != 0) begin
      if (o == MDU_DIV) begin
        rmag = longint'($signed(hi)); if (rmag < 0) rmag = -rmag;
        bmag = longint'($signed(y));  if (bmag < 0) bmag = -bmag;
      end else begin
        rmag = longint'(hi);
        bmag = longint'(y);
      end
      check({tag, " rem_lt_b"}, 64'(rmag < bmag), 64'd1);
    end
  endtask

  initial begin
    logic [2:0]  ops [4];
    logic [31:0] x, y;
    int          n, seen;
    ops[0] = MDU_MULT; ops[1] = MDU_MULTU; ops[2] = MDU_DIV; ops[3] = MDU_DIVU;

    rst_n = 1'b0; op_valid = 1'b0; op = MDU_NOP; a = '0; b = '0;
    tick(); tick();
    check("rst hi", 64'(hi), 64'd0);
    check("rst lo", 64'(lo), 64'd0);
    check("rst busy", 64'(busy), 64'd0);
    check("rst done", 64'(done), 64'd0);
    check("rst ready", 64'(op_ready), 64'd1);
    rst_n = 1'b1;
    tick();

    run_op(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max", 1'b1);
    check("multu_max const", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    run_op(MDU_MULT, 32'hFFFF_FFF9, 32'd3, "mult_neg", 1'b1);
    check("mult_neg const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op(MDU_DIV, 32'hFFFF_FFF9, 32'd2, "div_neg", 1'b1);
    check("div_neg const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(MDU_DIVU, 32'd100, 32'd0, "divu_zero", 1'b1);
    check("divu_zero const", {hi, lo}, 64'h0000_0064_FFFF_FFFF);
    run_op(MDU_DIV, 32'hFFFF_FF9C, 32'd0, "div_zero", 1'b1);
    check("div_zero const", {hi, lo}, 64'hFFFF_FF9C_FFFF_FFFF);
    run_op(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf", 1'b1);
    check("div_ovf const", {hi, lo}, 64'h0000_0000_8000_0000);
    run_op(MDU_MULT, 32'h8000_0000, 32'h8000_0000, "mult_min", 1'b1);
    check("mult_min const", {hi, lo}, 64'h4000_0000_0000_0000);
    run_op(MDU_DIV, 32'd7, 32'hFFFF_FFFE, "div_negb", 1'b1);

    // MTHI then MTLO back to back, then an undefined op
    op = MDU_MTHI; a = 32'h1234; op_valid = 1'b1;
    tick();
    check("mthi hi", 64'(hi), 64'h1234);
    check("mthi busy", 64'(busy), 64'd0);
    check("mthi ready", 64'(op_ready), 64'd1);
    op = MDU_MTLO; a = 32'h5678;
    tick();
    check("mtlo lo", 64'(lo), 64'h5678);
    check("mtlo hi", 64'(hi), 64'h1234);
    check("mtlo busy", 64'(busy), 64'd0);
    check("mtlo done", 64'(done), 64'd0);
    op = 3'd6; a = 32'hDEAD; b = 32'hBEEF;
    tick();
    check("undef busy", 64'(busy), 64'd0);
    check("undef hilo", {hi, lo}, 64'h0000_1234_0000_5678);
    op_valid = 1'b0;
    tick();

    // op_valid held through CALC with changing operands: second op waits for the done cycle
    op = MDU_MULTU; a = 32'd3; b = 32'd5; op_valid = 1'b1;
    tick();
    op = MDU_DIVU; a = 32'd50; b = 32'd5;
    n = 1;
    while (done !== 1'b1 && n < 60) begin
      check("hold ready_low", 64'(op_ready), 64'd0);
      tick();
      n++;
    end
    check("hold latency", 64'(n), 64'd34);
    check("hold first hilo", {hi, lo}, 64'd15);
    check("hold ready_done", 64'(op_ready), 64'd1);
    tick();
    op_valid = 1'b0;
    check("hold accepted busy", 64'(busy), 64'd1);
    n = 1;
    while (done !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    check("hold second latency", 64'(n), 64'd34);
    check("hold second hilo", {hi, lo}, 64'h0000_0000_0000_000A);

    // Reset in the middle of a divide
    op = MDU_DIVU; a = 32'd1000; b = 32'd7; op_valid = 1'b1;
    tick();
    op_valid = 1'b0;
    for (int i = 1; i < 10; i++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst ready", 64'(op_ready), 64'd1);
    check("midrst busy", 64'(busy), 64'd0);
    check("midrst hilo", {hi, lo}, 64'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1 || busy === 1'b1) seen++;
      tick();
    end
    check("midrst no done", 64'(seen), 64'd0);

    // Randomized ops, each accepted in the previous op's done cycle
    for (int i = 0; i < 1000; i++) begin
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 9))
        0: y = 32'd0;
        1: x = 32'h8000_0000;
        2: y = 32'($urandom_range(1, 20));
        3: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
        default: ;
      endcase
      run_op(ops[$urandom_range(0, 3)], x, y, "rand", 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
